// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops words while the FIFO is non-empty, packs
// PACK_RATIO of them into one wide beat and presents it on a valid/ready port.
module fifo_rd_packer #(
   parameter int FIFO_WIDTH = 32,
   parameter int PACK_RATIO = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             empty,
   output logic                             read_en,
   input  logic [FIFO_WIDTH-1:0]            data_out,
   input  logic                             flush,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [FIFO_WIDTH*PACK_RATIO-1:0] m_data,
   output logic [PACK_RATIO-1:0]            m_keep,
   output logic                             busy
);

   localparam int CW = $clog2(PACK_RATIO + 1);
   localparam int BW = FIFO_WIDTH * PACK_RATIO;
   localparam logic [CW-1:0] FULL_C  = CW'(PACK_RATIO);
   localparam logic [CW:0]   LIMIT_C = (CW + 1)'(PACK_RATIO);

   typedef enum logic [0:0] {
      ST_FILL  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     fill_q, fill_d;
   logic              rd_pend_q;
   logic [BW-1:0]     acc_q, acc_d;
   logic              m_valid_q, m_valid_d;
   logic [BW-1:0]     m_data_q, m_data_d;
   logic [PACK_RATIO-1:0] m_keep_q, m_keep_d;

   logic              out_free_s;
   logic              full_s;
   logic              emit_s;
   logic              read_en_s;
   logic [CW:0]       inflight_s;

   // Words already landed plus the one in flight bound further reads, so the
   // accumulator can never be overrun while the output register is stalled.
   assign inflight_s = {1'b0, fill_q} + {{CW{1'b0}}, rd_pend_q};
   assign read_en_s  = !rst && (state_q == ST_FILL) && !empty && (inflight_s < LIMIT_C);
   assign out_free_s = !m_valid_q || m_ready;
   assign full_s     = (fill_q == FULL_C);
   assign emit_s     = out_free_s &&
                       (full_s || ((state_q == ST_FLUSH) && !rd_pend_q && (fill_q != {CW{1'b0}})));

   assign read_en = read_en_s;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_keep  = m_keep_q;
   assign busy    = (fill_q != {CW{1'b0}}) || rd_pend_q || (state_q == ST_FLUSH) || m_valid_q;

   // Next-state: lane capture, beat transfer (full or flushed) and flush FSM.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      acc_d     = acc_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;

      if (rd_pend_q) begin
         for (int i = 0; i < PACK_RATIO; i++) begin
            if (fill_q == CW'(i)) begin
               acc_d[i*FIFO_WIDTH +: FIFO_WIDTH] = data_out;
            end else begin
               acc_d[i*FIFO_WIDTH +: FIFO_WIDTH] = acc_q[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
         end
         fill_d = fill_q + CW'(1);
      end else begin
         fill_d = fill_q;
      end

      // A full beat and a flushed partial beat share one path: lanes at or
      // above fill are zeroed and their keep bits cleared.
      if (emit_s) begin
         m_valid_d = 1'b1;
         for (int i = 0; i < PACK_RATIO; i++) begin
            if (CW'(i) < fill_q) begin
               m_data_d[i*FIFO_WIDTH +: FIFO_WIDTH] = acc_q[i*FIFO_WIDTH +: FIFO_WIDTH];
               m_keep_d[i] = 1'b1;
            end else begin
               m_data_d[i*FIFO_WIDTH +: FIFO_WIDTH] = {FIFO_WIDTH{1'b0}};
               m_keep_d[i] = 1'b0;
            end
         end
         fill_d = {CW{1'b0}};
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end

      case (state_q)
         ST_FILL: begin
            if (flush) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_FLUSH: begin
            if (!rd_pend_q && out_free_s) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FILL;
         fill_q    <= {CW{1'b0}};
         rd_pend_q <= 1'b0;
         acc_q     <= {BW{1'b0}};
         m_valid_q <= 1'b0;
         m_data_q  <= {BW{1'b0}};
         m_keep_q  <= {PACK_RATIO{1'b0}};
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         rd_pend_q <= read_en_s;
         acc_q     <= acc_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue-based FIFO model feeds the DUT and
// a scoreboard of expected beats is checked whenever a beat is accepted.
module tb_fifo_rd_packer;

   logic        clk;
   logic        rst;
   logic        empty;
   logic        read_en;
   logic [31:0] data_out;
   logic        flush;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;
   logic [1:0]  m_keep;
   logic        busy;

   logic [31:0] fifo_q[$];
   logic [63:0] exp_data_q[$];
   logic [1:0]  exp_keep_q[$];

   int          vectors;
   int          miscompares;
   int          pops;
   int          pops0;
   logic [31:0] rd_word;
   logic        got_rd;
   logic        prev_stall;
   logic [63:0] prev_data;

   fifo_rd_packer #(.FIFO_WIDTH(32), .PACK_RATIO(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .empty    (empty),
      .read_en  (read_en),
      .data_out (data_out),
      .flush    (flush),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_keep   (m_keep),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic [31:0] lo, input logic [31:0] hi);
      fifo_q.push_back(lo);
      fifo_q.push_back(hi);
      exp_data_q.push_back({hi, lo});
      exp_keep_q.push_back(2'b11);
   endtask

   // One clock cycle: entered just after a falling edge with inputs set.
   task automatic tick();
      empty  = (fifo_q.size() == 0);
      got_rd = 1'b0;
      #1;
      if (rst) chk("rst_read_en", 64'(read_en), 64'd0);
      if (read_en === 1'b1) begin
         chk("read_on_empty", 64'(empty), 64'd0);
         if (fifo_q.size() != 0) begin
            rd_word = fifo_q.pop_front();
            got_rd  = 1'b1;
            pops++;
         end
      end
      if (m_valid === 1'b1 && m_ready && !rst) begin
         if (exp_data_q.size() == 0) begin
            chk("unexpected_beat", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            chk("beat_data", m_data, exp_data_q.pop_front());
            chk("beat_keep", 64'(m_keep), 64'(exp_keep_q.pop_front()));
         end
      end
      if (m_valid === 1'b1 && !m_ready && prev_stall && !rst) chk("stall_stable", m_data, prev_data);
      prev_stall = (m_valid === 1'b1) && !m_ready && !rst;
      prev_data  = m_data;
      @(posedge clk);
      @(negedge clk);
      data_out = got_rd ? rd_word : 32'hDEAD_BEEF;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while ((exp_data_q.size() != 0 || busy !== 1'b0) && n < max_cycles) begin
         tick();
         n++;
      end
      chk("drain_queue", 64'(exp_data_q.size()), 64'd0);
      chk("drain_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      pops        = 0;
      prev_stall  = 1'b0;
      prev_data   = 64'd0;
      rst         = 1'b1;
      flush       = 1'b0;
      m_ready     = 1'b1;
      data_out    = 32'h0000_0000;

      // Reset for three cycles with data waiting in the FIFO.
      push_beat(32'h1111_1111, 32'h2222_2222);
      push_beat(32'h3333_3333, 32'h4444_4444);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_m_valid", 64'(m_valid), 64'd0);
         chk("rst_m_data", m_data, 64'd0);
         chk("rst_m_keep", 64'(m_keep), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
      end
      rst = 1'b0;

      // Two full beats in FIFO order.
      wait_idle(40);

      // Single word then flush: one-lane beat, upper lane zeroed.
      fifo_q.push_back(32'hAAAA_0001);
      exp_data_q.push_back(64'h0000_0000_AAAA_0001);
      exp_keep_q.push_back(2'b01);
      tick(); tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_idle(20);

      // Downstream stall: exactly four pops, then reads stop.
      m_ready = 1'b0;
      push_beat(32'h5000_0000, 32'h5000_0001);
      push_beat(32'h5000_0002, 32'h5000_0003);
      push_beat(32'h5000_0004, 32'h5000_0005);
      pops0 = pops;
      for (int k = 0; k < 20; k++) tick();
      chk("stall_pops", 64'(pops - pops0), 64'd4);
      chk("stall_read_en", 64'(read_en), 64'd0);
      chk("stall_m_valid", 64'(m_valid), 64'd1);
      chk("stall_head", m_data, 64'h5000_0001_5000_0000);
      m_ready = 1'b1;
      wait_idle(60);

      // Reset while a second-lane read is in flight: partial data discarded.
      fifo_q.push_back(32'hBAD0_0000);
      tick(); tick(); tick();
      fifo_q.push_back(32'hBAD0_0001);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      push_beat(32'hC000_0002, 32'hC000_0003);
      wait_idle(30);

      // Flush coinciding with a full-beat transfer: no extra empty beat.
      push_beat(32'hF000_0000, 32'hF000_0001);
      tick(); tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_full_valid", 64'(m_valid), 64'd1);
      tick(); tick();
      chk("flush_exit_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 5; k++) tick();
      wait_idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the synchronous FIFO. Pops FIFO_WIDTH-bit words while the FIFO is not empty and packs PACK_RATIO consecutive words into one wide beat.
- Presents each beat on a valid/ready output interface.
- A flush request emits a partially filled beat with a lane-keep mask.
- Drives only the FIFO read enable. Never reads while the FIFO is empty, so the FIFO's no-read-on-empty rule holds by construction.

Parameters:
- FIFO_WIDTH, 32, width of one FIFO word.
- PACK_RATIO, 2, words per output beat; legal range 2..8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- empty  input  1  FIFO empty flag.
- read_en  output  1  FIFO pop request.
- data_out  input  FIFO_WIDTH  FIFO read data; valid on the cycle after read_en=1.
- flush  input  1  single-cycle pulse; emit the partial beat.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  FIFO_WIDTH*PACK_RATIO  packed beat; lane i = bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- m_keep  output  PACK_RATIO  lane-valid mask; bit i set when lane i holds data.
- busy  output  1  high when fill!=0, rd_pend=1, state=FLUSH, or m_valid=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - m_valid=0, m_data=0, m_keep=0; fill=0, rd_pend=0, state=FILL; accumulator cleared.
  - read_en is 0 in any cycle where rst=1.
  - Data returned on the cycle after reset for a read issued before reset is discarded.
- Internal state:
  - Accumulator: PACK_RATIO lanes.
  - fill: 0..PACK_RATIO.
  - rd_pend: one read in flight.
  - Output register: m_data/m_keep/m_valid.
- read_en is combinational: read_en = !rst && state==FILL && !empty && (fill + rd_pend) < PACK_RATIO.
- rd_pend <= read_en.
- When rd_pend=1, data_out is written into lane[fill] and fill increments. The first popped word goes to lane 0 (LSBs).
- Transfer to output:
  - Trigger: fill==PACK_RATIO and the output register is free (m_valid=0, or m_valid && m_ready this cycle).
  - Action: m_data<=accumulator, m_keep<=all ones, m_valid<=1, fill<=0.
  - An incoming rd_pend word in the same cycle cannot occur, because reads stop at fill+rd_pend==PACK_RATIO.
- Output handshake:
  - m_valid stays high until m_ready=1.
  - m_data and m_keep are stable while m_valid && !m_ready.
  - When m_valid && m_ready and no new transfer occurs, m_valid<=0.
- Latency: a FIFO word popped at cycle t lands in the accumulator at t+1. A completed beat appears on m_valid no earlier than t+2 after its last pop.
- State machine:
  - FILL: normal operation. On flush=1, go to FLUSH; reads stop from the next cycle.
  - FLUSH: wait for rd_pend=0 and a free output register.
    - If fill>0: m_data<=accumulator with unfilled lanes zeroed, m_keep<=(1<<fill)-1, m_valid<=1, fill<=0.
    - If fill==0: emit nothing.
    - Either way, return to FILL.
- Simultaneous events and boundaries:
  - flush while in FLUSH is ignored.
  - flush in the same cycle as a full-beat transfer: the full beat goes out normally; FLUSH then finds fill==0 and emits nothing.
  - flush when fill==0 and rd_pend==1: wait for the word, then emit a 1-lane beat.
  - empty rising while rd_pend=1 does not drop the pending word.
  - m_ready=0 indefinitely: the accumulator fills to PACK_RATIO, then read_en stays 0. The FIFO backs up; no data is lost or overwritten.
  - Reset mid-beat or mid-flush discards all partial data; no beat is emitted.
- Throughput: with PACK_RATIO=2, empty=0 and m_ready=1, reads occur in cycles c, c+1, c+4, c+5, … (exactly 2 idle read cycles per beat).

Test Plan:
- Reset held 3 cycles with empty=0 -> read_en=0, m_valid=0, m_data=0, m_keep=0 throughout; busy=0.
- FIFO preloaded with 0x11111111, 0x22222222, 0x33333333, 0x44444444; m_ready=1 -> two beats: m_data=0x2222222211111111 then 0x4444444433333333, m_keep=2'b11; read_en never high while empty=1.
- FIFO holds a single word 0xAAAA0001; flush pulse after it lands -> one beat m_data=0x00000000AAAA0001, m_keep=2'b01; then busy=0.
- m_ready=0 for 20 cycles with 6 words queued -> exactly 4 pops (2 in the output register, 2 in the accumulator), read_en=0 afterwards, m_data stable; release m_ready -> beats in order, no loss.
- rst asserted the cycle after read_en=1 with fill=1 -> no beat emitted, fill=0; the word returned after reset is discarded; the next beat after reset starts at lane 0.
- flush asserted in the same cycle as a full transfer (PACK_RATIO=2) -> one full beat with m_keep=2'b11, no extra empty beat, FLUSH exits to FILL within 2 cycles.
